hex_keypad_emulator: RTL and testbench

- Synthesizable model of a 4x4 hex keypad: the responder end of the scanner's Col/Row matrix interface.
- Accepts key-press commands (4-bit code, req/ack handshake) from a stimulus controller or host.
- Drives Row in response to the scanner's Col drive, with contact bounce, hold time and release gap.
- Sits in place of the passive row-signal model, so scanner regressions and FPGA bring-up run without a physical keypad.

---
 rtl/hex_keypad_emulator.sv | 144 ++++++++++++++
 tb/tb_hex_keypad_emulator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_keypad_emulator.sv
// Behavioural 4x4 hex keypad for scanner bring-up: presses one key per
// req/ack command, with contact chatter, a stable hold and a release gap.
module hex_keypad_emulator #(
  parameter int BOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 60,
  parameter int GAP_CYCLES    = 20,
  parameter int CW            = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_req,
  output logic       key_ack,
  input  logic       key_abort,
  output logic       busy,
  output logic       done,
  input  logic [3:0] Col,
  output logic [3:0] Row
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } state_t;

  localparam bit            HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
  localparam logic [CW-1:0] BOUNCE_LOAD = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    code_reg, code_next;
  logic          ack_reg, ack_next;
  logic          contact;
  logic          phase_end;
  logic          bounce_odd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      code_reg  <= 4'h0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      ack_reg   <= ack_next;
    end
  end

  assign phase_end = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = phase_end ? cnt_reg : cnt_reg - CW'(1);
    code_next  = code_reg;
    ack_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (key_req) begin
          code_next = key_code;
          ack_next  = 1'b1;
          if (HAS_BOUNCE) begin
            state_next = BOUNCE_IN;
            cnt_next   = BOUNCE_LOAD;
          end else begin
            state_next = HOLD;
            cnt_next   = HOLD_LOAD;
          end
        end
      end
      BOUNCE_IN: begin
        if (key_abort) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else if (phase_end) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end
      end
      HOLD: begin
        // Abort wins over the normal end of hold, so BOUNCE_OUT is skipped.
        if (key_abort) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else if (phase_end) begin
          if (HAS_BOUNCE) begin
            state_next = BOUNCE_OUT;
            cnt_next   = BOUNCE_LOAD;
          end else begin
            state_next = GAP;
            cnt_next   = GAP_LOAD;
          end
        end
      end
      BOUNCE_OUT: begin
        if (key_abort || phase_end) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end
      end
      GAP: begin
        if (phase_end) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Odd position within a bounce phase, counted from the phase's first cycle.
  assign bounce_odd = BOUNCE_LOAD[0] ^ cnt_reg[0];

  always_comb begin
    contact = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_reg)
      IDLE:       busy    = 1'b0;
      BOUNCE_IN:  contact = ~bounce_odd;
      HOLD:       contact = 1'b1;
      BOUNCE_OUT: contact = bounce_odd;
      GAP:        done    = phase_end;
      default:    busy    = 1'b0;
    endcase
  end

  assign key_ack = ack_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign Row[gi] = contact && (code_reg[3:2] == 2'(gi)) && Col[code_reg[1:0]];
  end

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Scoreboard bench: two emulators (no bounce / 4-cycle bounce); stimulus queues
// expected presses, a negedge monitor checks Row/busy/done cycle by cycle.
module tb_hex_keypad_emulator;

  localparam int HOLD = 60;
  localparam int GAP  = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic [3:0] col;
  logic       rotate;
  logic       key_req   [2];
  logic       key_abort [2];
  logic       key_ack   [2];
  logic       busy      [2];
  logic       done      [2];
  logic [3:0] row       [2];

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    hex_keypad_emulator #(
      .BOUNCE_CYCLES((gi == 0) ? 0 : 4),
      .HOLD_CYCLES(HOLD),
      .GAP_CYCLES(GAP),
      .CW(16)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .key_code(key_code),
      .key_req(key_req[gi]),
      .key_ack(key_ack[gi]),
      .key_abort(key_abort[gi]),
      .busy(busy[gi]),
      .done(done[gi]),
      .Col(col),
      .Row(row[gi])
    );
  end

  typedef struct {
    int         dut;
    logic [3:0] code;
    int         abort_at;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // monitor state
  bit   trk = 0;
  exp_t cur;
  int   t, len, pend, bcyc, errs;
  int   e_t;
  logic [3:0] e_act, e_req;

  function automatic logic exp_contact(int tt, int b, int pe);
    if (tt >= pe) return 1'b0;
    if (tt < b) return (tt % 2) == 0;
    if (tt < b + HOLD) return 1'b1;
    return ((tt - b - HOLD) % 2) == 1;
  endfunction

  task automatic idle_check(int d);
    total++;
    if (row[d] !== 4'b0 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
      bad++;
      $display("FAIL idle dut=%0d row=%b busy=%b done=%b required row=0000 busy=0 done=0",
               d, row[d], busy[d], done[d]);
    end
  endtask

  // Monitor: pops an expected press on key_ack, then follows it to completion.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        trk = 0;
        for (int d = 0; d < 2; d++) idle_check(d);
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (key_ack[d] === 1'b1) begin
            if (trk || exp_q.size() == 0 || exp_q[0].dut != d) begin
              total++;
              bad++;
              $display("FAIL unexpected_ack dut=%0d actual=1 required=0", d);
            end else begin
              cur  = exp_q.pop_front();
              trk  = 1;
              t    = 0;
              errs = 0;
              bcyc = (cur.dut == 0) ? 0 : 4;
              pend = 2 * bcyc + HOLD;
              if (cur.abort_at >= 0 && cur.abort_at < pend) pend = cur.abort_at + 1;
              len  = pend + GAP;
            end
          end
        end
        for (int d = 0; d < 2; d++) begin
          if (trk && cur.dut == d) begin
            logic [3:0] er;
            logic       eb, ed;
            er = 4'b0;
            if (exp_contact(t, bcyc, pend) && col[cur.code[1:0]])
              er = 4'b0001 << cur.code[3:2];
            eb = (t < len);
            ed = (t == len - 1);
            if (row[d] !== er || busy[d] !== eb || done[d] !== ed) begin
              if (errs == 0) begin
                e_t   = t;
                e_act = {1'b0, row[d][2:0]} | {row[d][3], 3'b0};
                e_req = er;
              end
              errs++;
            end
            t++;
            if (t > len) begin
              total++;
              if (errs != 0) begin
                bad++;
                $display("FAIL trace dut=%0d code=%h abort_at=%0d errs=%0d first t=%0d row actual=%b required=%b",
                         d, cur.code, cur.abort_at, errs, e_t, e_act, e_req);
              end else begin
                $display("xact dut=%0d code=%h abort_at=%0d busy_len=%0d ok",
                         d, cur.code, cur.abort_at, len);
              end
              trk = 0;
            end
          end else begin
            idle_check(d);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rotate) col = {col[2:0], col[3]};
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, logic [3:0] act, logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic press(int d, logic [3:0] code, int abort_at, bit keep_req);
    exp_t e;
    int   n;
    e.dut = d;
    e.code = code;
    e.abort_at = abort_at;
    exp_q.push_back(e);
    key_code = code;
    key_req[d] = 1'b1;
    tick();
    n = 0;
    while (key_ack[d] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (key_ack[d] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ack_timeout dut=%0d actual=0 required=1", d);
    end
    if (!keep_req) key_req[d] = 1'b0;
    if (abort_at >= 0) begin
      repeat (abort_at) tick();
      key_abort[d] = 1'b1;
      tick();
      key_abort[d] = 1'b0;
    end
  endtask

  task automatic wait_idle(int d);
    int n;
    n = 0;
    while (busy[d] !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    if (busy[d] !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL busy_timeout dut=%0d actual=1 required=0", d);
    end
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    key_code = 4'h0;
    col = 4'b0000;
    rotate = 1'b0;
    for (int d = 0; d < 2; d++) begin
      key_req[d] = 1'b0;
      key_abort[d] = 1'b0;
    end
    repeat (3) tick();
    col = 4'b1111;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_row", row[d], 4'b0000);
      check("reset_flags", {1'b0, key_ack[d], busy[d], done[d]}, 4'b0000);
    end
    reset = 1'b1;
    repeat (2) tick();

    // code 5, no bounce, rotating single-column scan
    col = 4'b0001;
    rotate = 1'b1;
    press(0, 4'h5, -1, 0);
    wait_idle(0);
    rotate = 1'b0;

    // code F, 4-cycle bounce, column 3 held
    col = 4'b1000;
    press(1, 4'hF, -1, 0);
    wait_idle(1);

    // sweep all codes, every column driven and then none
    col = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      press(1, 4'(c), -1, 0);
      wait_idle(1);
    end
    col = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      press(1, 4'(c), -1, 0);
      wait_idle(1);
    end
    col = 4'b1111;

    // request during HOLD of 0xA is ignored; kept high it starts 0x3 after done
    press(1, 4'hA, -1, 0);
    repeat (20) tick();
    begin
      exp_t e;
      e.dut = 1;
      e.code = 4'h3;
      e.abort_at = -1;
      exp_q.push_back(e);
    end
    key_code = 4'h3;
    key_req[1] = 1'b1;
    wait_idle(1);
    n = 0;
    while (key_ack[1] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    key_req[1] = 1'b0;
    wait_idle(1);

    // aborts: 10th HOLD cycle, during BOUNCE_IN, on last HOLD cycle, during GAP (ignored)
    press(0, 4'h9, 9, 0);
    wait_idle(0);
    press(1, 4'h6, 2, 0);
    wait_idle(1);
    press(1, 4'hC, 63, 0);
    wait_idle(1);
    press(0, 4'h1, 65, 0);
    wait_idle(0);

    // reset in the middle of HOLD
    press(0, 4'h6, -1, 0);
    repeat (20) tick();
    reset = 1'b0;
    #1;
    check("midreset_row", row[0], 4'b0000);
    check("midreset_busy", {3'b0, busy[0]}, 4'b0000);
    check("midreset_ack", {3'b0, key_ack[0]}, 4'b0000);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("post_reset_busy", {3'b0, busy[0]}, 4'b0000);
    press(0, 4'h2, -1, 0);
    wait_idle(0);

    repeat (5) tick();
    total++;
    if (exp_q.size() != 0 || trk) begin
      bad++;
      $display("FAIL leftover pending=%0d tracking=%0d required pending=0 tracking=0",
               exp_q.size(), trk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
